// File: rtl/add_pkg.sv
// Shared definitions for the registered ripple-carry adder.
//   ADD_WIDTH  : default operand/result width
//   add_word_t : one operand or sum word of the default width
package add_pkg;

  localparam int unsigned ADD_WIDTH = 20;

  typedef logic [ADD_WIDTH-1:0] add_word_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half adders plus an OR.
// Ports:
//   x, y : operand bits
//   cin  : carry in
//   s    : sum bit, x ^ y ^ cin
//   c    : carry out, (x & y) | (cin & (x ^ y))
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic c
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  // First half adder: operand bits.
  assign ha0_s = x ^ y;
  assign ha0_c = x & y;

  // Second half adder: partial sum with the incoming carry.
  assign s     = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;

  // The two half-adder carries can never both be 1, so OR is enough.
  assign c     = ha0_c | ha1_c;

endmodule

// File: rtl/add_20.sv
// Registered unsigned ripple-carry adder: {cout, out} = a + b, one cycle of latency.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset; clears out, cout, out_valid
//   in_valid  : a/b are valid this cycle
//   a, b      : unsigned operands
//   out       : registered sum modulo 2^WIDTH
//   cout      : registered carry out of the MSB
//   out_valid : out/cout were loaded from a valid input on the last edge
// WIDTH must be at least 1.
module add_20 import add_pkg::*; #(
  parameter int unsigned WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             out_valid
);

  // carry[i] feeds bit i; carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_cell u_fa (
      .x   (a[i]),
      .y   (b[i]),
      .cin (carry[i]),
      .s   (sum[i]),
      .c   (carry[i+1])
    );
  end

  logic [WIDTH-1:0] sum_d,   sum_q;
  logic             cout_d,  cout_q;
  logic             valid_d, valid_q;

  // Result registers only load on a valid input, so junk (even X/Z) on a/b
  // while in_valid is low never reaches the held result.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = sum;
      cout_d = carry[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign out       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_add_20.sv
module tb_add_20;
  import add_pkg::*;

  logic      clk;
  logic      rst;
  logic      in_valid;
  add_word_t a;
  add_word_t b;
  add_word_t out;
  logic      cout;
  logic      out_valid;

  logic fa_x, fa_y, fa_cin, fa_s, fa_c;

  int checks;
  int failures;

  typedef struct {
    logic      valid;
    add_word_t sum;
    logic      cout;
  } exp_t;

  typedef struct {
    string     name;
    logic      v;
    add_word_t a;
    add_word_t b;
    add_word_t exp_out;
    logic      exp_cout;
    logic      exp_valid;
  } vec_t;

  exp_t exp_q[$];

  // Reference state: what out/cout should be holding.
  add_word_t m_out;
  logic      m_cout;

  add_20 #(.WIDTH(ADD_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out       (out),
    .cout      (cout),
    .out_valid (out_valid)
  );

  full_adder_cell u_cell (
    .x   (fa_x),
    .y   (fa_y),
    .cin (fa_cin),
    .s   (fa_s),
    .c   (fa_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string name, input exp_t e);
    checks++;
    if (out !== e.sum || cout !== e.cout || out_valid !== e.valid) begin
      failures++;
      $display("FAIL %s: got out=%h cout=%b valid=%b, expected out=%h cout=%b valid=%b",
               name, out, cout, out_valid, e.sum, e.cout, e.valid);
    end
  endtask

  // Called at a negedge: drive inputs, push expectation, wait one edge, pop and compare.
  task automatic step(input string name, input logic v, input add_word_t x, input add_word_t y,
                      input add_word_t e_out, input logic e_cout, input logic e_valid);
    exp_t e;
    in_valid = v;
    a        = x;
    b        = y;
    exp_q.push_back('{valid: e_valid, sum: e_out, cout: e_cout});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check_out(name, e);
  endtask

  // Same as step, but the expectation comes from a behavioural a+b model.
  task automatic step_model(input string name, input logic v, input add_word_t x,
                            input add_word_t y);
    logic [ADD_WIDTH:0] full;
    if (v) begin
      full   = {1'b0, x} + {1'b0, y};
      m_out  = full[ADD_WIDTH-1:0];
      m_cout = full[ADD_WIDTH];
    end
    step(name, v, x, y, m_out, m_cout, v);
  endtask

  vec_t vecs[8];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    m_out    = '0;
    m_cout   = 1'b0;

    // Exhaustive full-adder cell: s = parity, c = majority.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] bits;
      logic       e_s, e_c;
      bits   = i[2:0];
      fa_x   = bits[2];
      fa_y   = bits[1];
      fa_cin = bits[0];
      #1;
      e_s = bits[2] ^ bits[1] ^ bits[0];
      e_c = (bits[2] & bits[1]) | (bits[2] & bits[0]) | (bits[1] & bits[0]);
      checks++;
      if (fa_s !== e_s || fa_c !== e_c) begin
        failures++;
        $display("FAIL cell x=%b y=%b cin=%b: got s=%b c=%b, expected s=%b c=%b",
                 fa_x, fa_y, fa_cin, fa_s, fa_c, e_s, e_c);
      end
    end

    // Reset state, held across a clock edge.
    @(posedge clk);
    @(negedge clk);
    check_out("reset", '{valid: 1'b0, sum: '0, cout: 1'b0});
    rst = 1'b0;

    vecs[0] = '{"zero",        1'b1, 20'h00000, 20'h00000, 20'h00000, 1'b0, 1'b1};
    vecs[1] = '{"ident_b",     1'b1, 20'h00000, 20'h7FFFF, 20'h7FFFF, 1'b0, 1'b1};
    vecs[2] = '{"ident_a",     1'b1, 20'h7FFFF, 20'h00000, 20'h7FFFF, 1'b0, 1'b1};
    vecs[3] = '{"ripple_7f",   1'b1, 20'h7FFFF, 20'h7FFFF, 20'hFFFFE, 1'b0, 1'b1};
    vecs[4] = '{"ripple_full", 1'b1, 20'hFFFFF, 20'h00001, 20'h00000, 1'b1, 1'b1};
    vecs[5] = '{"hold_idle",   1'b0, 20'h12345, 20'hFEDCB, 20'h00000, 1'b1, 1'b0};
    vecs[6] = '{"hold_idle2",  1'b0, 20'hFFFFF, 20'hFFFFF, 20'h00000, 1'b1, 1'b0};
    vecs[7] = '{"ripple_55",   1'b1, 20'h55555, 20'h55555, 20'hAAAAA, 1'b0, 1'b1};

    // Consecutive entries go on consecutive edges (back-to-back throughput).
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].name, vecs[i].v, vecs[i].a, vecs[i].b,
           vecs[i].exp_out, vecs[i].exp_cout, vecs[i].exp_valid);
    end

    // Asynchronous reset between edges while out=0xAAAAA.
    in_valid = 1'b1;
    a        = 20'h11111;
    b        = 20'h22222;
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", '{valid: 1'b0, sum: '0, cout: 1'b0});
    @(posedge clk);
    @(negedge clk);
    check_out("rst_held", '{valid: 1'b0, sum: '0, cout: 1'b0});
    rst    = 1'b0;
    m_out  = '0;
    m_cout = 1'b0;
    step("idle_after_rst", 1'b0, 20'h0F0F0, 20'h0F0F0, 20'h00000, 1'b0, 1'b0);
    step("after_rst", 1'b1, 20'h00001, 20'h00002, 20'h00003, 1'b0, 1'b1);
    m_out  = 20'h00003;
    m_cout = 1'b0;

    // Random regression against the behavioural model.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra, rb, rv;
      ra = $urandom;
      rb = $urandom;
      rv = $urandom_range(0, 3);
      step_model("random", rv != 0, ra[ADD_WIDTH-1:0], rb[ADD_WIDTH-1:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
